// File: rtl/fetch_prefetch_pkg.sv
// Shared types for the fetch prefetch unit: bus request mode, fetch FSM states, default widths.
package fetch_prefetch_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic {
      MEMREQ_READ  = 1'b0,
      MEMREQ_WRITE = 1'b1
   } memreq_mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous show-ahead FIFO holding {pc, instr} entries; flush overrides push and pop.
module fetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [W-1:0]             wdata_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [W-1:0]             rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Sequential instruction prefetcher: one outstanding bus read at a time, buffered into a
// show-ahead queue for decode, with redirect flushing the queue and dropping the in-flight reply.
module fetch_prefetch
   import fetch_prefetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = DEF_ADDR_W,
   parameter int unsigned       DATA_W   = DEF_DATA_W,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enabled,
   input  logic                  redirect_valid,
   input  logic [ADDR_W-1:0]     redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_W-1:0]     out_pc,
   output logic [DATA_W-1:0]     out_instr,
   output logic                  request_enable,
   output logic                  mode,
   output logic [ADDR_W-1:0]     addr,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   input  logic                  response_enable,
   input  logic [DATA_W-1:0]     data
);

   localparam int unsigned       CNT_W    = $clog2(DEPTH) + 1;
   localparam int unsigned       STRB_W   = DATA_W / 8;
   localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(STRB_W);
   localparam logic [ADDR_W-1:0] PC_ALIGN = ~ADDR_W'(3);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              discard_q, discard_d;
   logic              req_q, req_d;
   logic              push_c, pop_c;
   logic [CNT_W-1:0]  count_c;
   logic [ADDR_W+DATA_W-1:0] head_c;

   assign out_valid = (count_c != '0);
   assign pop_c     = out_valid && out_ready && !redirect_valid;

   // Redirect has priority: it blocks issue, suppresses push and marks an outstanding reply stale.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      issue_pc_d = issue_pc_q;
      addr_d     = addr_q;
      discard_d  = discard_q;
      req_d      = 1'b0;
      push_c     = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_pc & PC_ALIGN;
            end else if (enabled && (count_c < CNT_W'(DEPTH))) begin
               req_d      = 1'b1;
               addr_d     = fetch_pc_q;
               issue_pc_d = fetch_pc_q;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) fetch_pc_d = redirect_pc & PC_ALIGN;
            if (response_enable) begin
               if (!discard_q && !redirect_valid) begin
                  push_c     = 1'b1;
                  fetch_pc_d = issue_pc_q + PC_STEP;
               end
               discard_d = 1'b0;
               state_d   = IDLE;
            end else if (redirect_valid) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         issue_pc_q <= '0;
         addr_q     <= '0;
         discard_q  <= 1'b0;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         issue_pc_q <= issue_pc_d;
         addr_q     <= addr_d;
         discard_q  <= discard_d;
         req_q      <= req_d;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .W     (ADDR_W + DATA_W)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_c),
      .wdata_i ({issue_pc_q, data}),
      .pop_i   (pop_c),
      .flush_i (redirect_valid),
      .rdata_o (head_c),
      .count_o (count_c)
   );

   assign {out_pc, out_instr} = head_c;
   assign request_enable      = req_q;
   assign addr                = addr_q;
   assign mode                = MEMREQ_READ;
   assign wdata               = '0;
   assign wstrb               = '0;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Scoreboard bench for fetch_prefetch with a fixed-latency bus responder model.
module tb_fetch_prefetch;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enabled = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_ready = 1'b0;
   logic        response_enable = 1'b0;
   logic [31:0] data = '0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        request_enable;
   logic        mode;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   logic [31:0] req_log[$];
   logic [31:0] pop_log[$];
   logic [31:0] pend_addr = '0;
   int          rsp_cnt = 0;
   bit          tb_outstanding = 1'b0;
   bit          tb_discard = 1'b0;

   fetch_prefetch dut (
      .clk             (clk),
      .rst             (rst),
      .enabled         (enabled),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_instr       (out_instr),
      .request_enable  (request_enable),
      .mode            (mode),
      .addr            (addr),
      .wdata           (wdata),
      .wstrb           (wstrb),
      .response_enable (response_enable),
      .data            (data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memw(input logic [31:0] a);
      logic [31:0] r;
      r = a * 32'd2654435761;
      return r ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] req_at(input int i);
      return (i < req_log.size()) ? req_log[i] : 32'hDEAD_DEAD;
   endfunction

   function automatic logic [31:0] pop_at(input int i);
      return (i < pop_log.size()) ? pop_log[i] : 32'hDEAD_DEAD;
   endfunction

   // One clock: check outputs against the model, update the model, then advance the bus responder.
   task automatic tick();
      bit exp_v;
      exp_v = (exp_q.size() != 0);
      checks++;
      if (out_valid !== exp_v) begin
         failures++;
         $display("FAIL out_valid @%0t: got %b required %b", $time, out_valid, exp_v);
      end
      if (out_valid === 1'b1 && exp_v) begin
         checks++;
         if ({out_pc, out_instr} !== exp_q[0]) begin
            failures++;
            $display("FAIL head @%0t: got pc=%h instr=%h required pc=%h instr=%h",
                     $time, out_pc, out_instr, exp_q[0][63:32], exp_q[0][31:0]);
         end
      end
      if (rst) begin
         exp_q.delete();
         tb_outstanding = 1'b0;
         tb_discard     = 1'b0;
      end else begin
         if (out_valid === 1'b1 && out_ready && !redirect_valid && exp_v) begin
            pop_log.push_back(out_pc);
            void'(exp_q.pop_front());
         end
         if (redirect_valid) begin
            exp_q.delete();
            if (tb_outstanding && !response_enable) tb_discard = 1'b1;
         end
         if (response_enable) begin
            if (tb_outstanding && !tb_discard && !redirect_valid)
               exp_q.push_back({pend_addr, memw(pend_addr)});
            tb_outstanding = 1'b0;
            tb_discard     = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      if (request_enable === 1'b1) begin
         req_log.push_back(addr);
         pend_addr      = addr;
         rsp_cnt        = LAT;
         tb_outstanding = 1'b1;
      end
      response_enable = 1'b0;
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            response_enable = 1'b1;
            data            = memw(pend_addr);
         end
      end
   endtask

   task automatic wait_req(input int n, input int budget, input string name);
      int k = 0;
      while (req_log.size() < n && k < budget) begin
         tick();
         k++;
      end
      checks++;
      if (req_log.size() < n) begin
         failures++;
         $display("FAIL %s: requests seen %0d required %0d", name, req_log.size(), n);
      end
   endtask

   task automatic wait_pops(input int n, input int budget, input string name);
      int k = 0;
      while (pop_log.size() < n && k < budget) begin
         tick();
         k++;
      end
      checks++;
      if (pop_log.size() < n) begin
         failures++;
         $display("FAIL %s: pops seen %0d required %0d", name, pop_log.size(), n);
      end
   endtask

   task automatic restart();
      int k = 0;
      enabled        = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      while (k < 50 && (tb_outstanding || rsp_cnt != 0 || response_enable)) begin
         tick();
         k++;
      end
      rst = 1'b1;
      exp_q.delete();
      #1;
      tick();
      tick();
      rst = 1'b0;
      req_log.delete();
      pop_log.delete();
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      checks += 8;
      if (request_enable !== 1'b0) begin failures++; $display("FAIL rst_req: got %b required 0", request_enable); end
      if (mode !== 1'b0)           begin failures++; $display("FAIL rst_mode: got %b required 0", mode); end
      if (addr !== 32'h0)          begin failures++; $display("FAIL rst_addr: got %h required 0", addr); end
      if (wdata !== 32'h0)         begin failures++; $display("FAIL rst_wdata: got %h required 0", wdata); end
      if (wstrb !== 4'h0)          begin failures++; $display("FAIL rst_wstrb: got %h required 0", wstrb); end
      if (out_valid !== 1'b0)      begin failures++; $display("FAIL rst_valid: got %b required 0", out_valid); end
      if (out_pc !== 32'h0)        begin failures++; $display("FAIL rst_pc: got %h required 0", out_pc); end
      if (out_instr !== 32'h0)     begin failures++; $display("FAIL rst_instr: got %h required 0", out_instr); end
      tick();
      tick();
      rst     = 1'b0;
      enabled = 1'b1;
      tick();
      checks += 2;
      if (request_enable !== 1'b1) begin failures++; $display("FAIL first_req: got %b required 1", request_enable); end
      if (addr !== 32'h0)          begin failures++; $display("FAIL first_addr: got %h required 0", addr); end
      tick();
      checks++;
      if (request_enable !== 1'b0) begin failures++; $display("FAIL req_pulse: got %b required 0", request_enable); end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      wait_pops(4, 100, "stream_pops");
      for (int i = 0; i < 4; i++) begin
         checks += 2;
         if (pop_at(i) !== 32'(i * 4)) begin
            failures++;
            $display("FAIL stream_pop%0d: got %h required %h", i, pop_at(i), 32'(i * 4));
         end
         if (req_at(i) !== 32'(i * 4)) begin
            failures++;
            $display("FAIL stream_req%0d: got %h required %h", i, req_at(i), 32'(i * 4));
         end
      end
   endtask

   task automatic test_full();
      restart();
      enabled = 1'b1;
      repeat (40) tick();
      checks += 2;
      if (req_log.size() != 4) begin failures++; $display("FAIL full_reqs: got %0d required 4", req_log.size()); end
      if (out_valid !== 1'b1)  begin failures++; $display("FAIL full_valid: got %b required 1", out_valid); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (req_at(i) !== 32'(i * 4)) begin
            failures++;
            $display("FAIL full_req%0d: got %h required %h", i, req_at(i), 32'(i * 4));
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      repeat (10) tick();
      checks += 2;
      if (req_log.size() != 5)   begin failures++; $display("FAIL full_reqs_after_pop: got %0d required 5", req_log.size()); end
      if (req_at(4) !== 32'h10)  begin failures++; $display("FAIL full_req4: got %h required 10", req_at(4)); end
   endtask

   task automatic test_redirect_wait();
      restart();
      enabled = 1'b1;
      wait_req(3, 40, "rdw_req3");
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rdw_valid: got %b required 0", out_valid); end
      wait_req(4, 40, "rdw_req4");
      checks++;
      if (req_at(3) !== 32'h100) begin failures++; $display("FAIL rdw_addr: got %h required 100", req_at(3)); end
      out_ready = 1'b1;
      wait_pops(2, 40, "rdw_pops");
      checks += 2;
      if (pop_at(0) !== 32'h100) begin failures++; $display("FAIL rdw_pop0: got %h required 100", pop_at(0)); end
      if (pop_at(1) !== 32'h104) begin failures++; $display("FAIL rdw_pop1: got %h required 104", pop_at(1)); end
   endtask

   task automatic test_redirect_response();
      int k = 0;
      restart();
      enabled = 1'b1;
      wait_req(2, 40, "rdr_req2");
      while (!response_enable && k < 20) begin
         tick();
         k++;
      end
      checks += 2;
      if (response_enable !== 1'b1) begin failures++; $display("FAIL rdr_rsp: got %b required 1", response_enable); end
      if (out_valid !== 1'b1)       begin failures++; $display("FAIL rdr_head: got %b required 1", out_valid); end
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      tick();
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rdr_flush: got %b required 0", out_valid); end
      k = 0;
      while (out_valid !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      checks++;
      if (out_pc !== 32'h200) begin failures++; $display("FAIL rdr_pc: got %h required 200", out_pc); end
      pop_log.delete();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      req_log.delete();
      wait_req(2, 40, "wrap_reqs");
      checks += 2;
      if (req_at(0) !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req0: got %h required fffffffc", req_at(0)); end
      if (req_at(1) !== 32'h0)         begin failures++; $display("FAIL wrap_req1: got %h required 0", req_at(1)); end
      wait_pops(2, 40, "wrap_pops");
      checks += 2;
      if (pop_at(0) !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pop0: got %h required fffffffc", pop_at(0)); end
      if (pop_at(1) !== 32'h0)         begin failures++; $display("FAIL wrap_pop1: got %h required 0", pop_at(1)); end
   endtask

   task automatic test_reset_mid();
      restart();
      enabled = 1'b1;
      wait_req(3, 40, "rm_req3");
      enabled = 1'b0;
      #2 rst = 1'b1;
      exp_q.delete();
      tb_outstanding = 1'b0;
      tb_discard     = 1'b0;
      #1;
      checks += 3;
      if (request_enable !== 1'b0) begin failures++; $display("FAIL rm_req: got %b required 0", request_enable); end
      if (addr !== 32'h0)          begin failures++; $display("FAIL rm_addr: got %h required 0", addr); end
      if (out_valid !== 1'b0)      begin failures++; $display("FAIL rm_valid: got %b required 0", out_valid); end
      tick();
      rst = 1'b0;
      repeat (4) tick();
      checks += 2;
      if (req_log.size() != 3) begin failures++; $display("FAIL rm_noreq: got %0d required 3", req_log.size()); end
      if (out_valid !== 1'b0)  begin failures++; $display("FAIL rm_late: got %b required 0", out_valid); end
      req_log.delete();
      pop_log.delete();
      enabled   = 1'b1;
      out_ready = 1'b1;
      wait_req(1, 20, "rm_first");
      checks++;
      if (req_at(0) !== 32'h0) begin failures++; $display("FAIL rm_pc: got %h required 0", req_at(0)); end
      wait_pops(1, 20, "rm_pop");
      checks++;
      if (pop_at(0) !== 32'h0) begin failures++; $display("FAIL rm_pop0: got %h required 0", pop_at(0)); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_response();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
